matmul_accel_nxn: RTL and testbench

MATMUL_ACCEL_NXN -- requirements
Module: matmul_accel_nxn

---
 rtl/matmul_accel_nxn.sv | 238 +++++++++++++++++++++++
 tb/tb_matmul_accel_nxn.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_accel_nxn.sv
// Memory-mapped N x N signed matrix multiplier on an output-stationary systolic grid.
// Ports: clk/rst, bus wen/ren/addr/wdata, registered rdata/rvalid, level irq.
module matmul_accel_nxn #(
  parameter int          WIDTH        = 16,
  parameter int          N            = 4,
  parameter logic [31:0] BASE_ADDRESS = 32'h1000_0040
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wen,
  input  logic               ren,
  input  logic [21:0]        addr,
  input  logic [31:0]        wdata,
  output logic [2*WIDTH-1:0] rdata,
  output logic               rvalid,
  output logic               irq
);
  localparam int NN = N * N;
  localparam int PW = 2 * WIDTH;
  localparam int IW = $clog2(NN);
  localparam int CW = $clog2(3 * N);
  localparam logic [CW-1:0] LAST = CW'(3 * N - 2);
  localparam logic [19:0] A_W = 20'h040;
  localparam logic [19:0] B_W = 20'h080;
  localparam logic [19:0] C_W = 20'h100;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e state_q, state_d;

  logic signed [WIDTH-1:0] a_q  [NN];
  logic signed [WIDTH-1:0] a_d  [NN];
  logic signed [WIDTH-1:0] b_q  [NN];
  logic signed [WIDTH-1:0] b_d  [NN];
  logic signed [WIDTH-1:0] ah_q [NN];
  logic signed [WIDTH-1:0] ah_d [NN];
  logic signed [WIDTH-1:0] bv_q [NN];
  logic signed [WIDTH-1:0] bv_d [NN];
  logic [PW-1:0]           acc_q [NN];
  logic [PW-1:0]           acc_d [NN];

  logic [CW-1:0] cnt_q, cnt_d;
  logic          irq_en_q, irq_en_d;
  logic          err_q, err_d;
  logic          rvalid_q, rvalid_d;
  logic [PW-1:0] rdata_q, rdata_d;
  logic          busy, done;

  // Address decode on word offsets relative to the window base
  logic [19:0]   widx, a_rel, b_rel, c_rel;
  logic          hit_ctrl, hit_stat, hit_a, hit_b, hit_c;
  logic [IW-1:0] a_ix, b_ix, c_ix;
  logic          unused_ok;

  assign widx     = addr[21:2] - BASE_ADDRESS[21:2];
  assign a_rel    = widx - A_W;
  assign b_rel    = widx - B_W;
  assign c_rel    = widx - C_W;
  assign hit_ctrl = (widx == 20'd0);
  assign hit_stat = (widx == 20'd1);
  assign hit_a    = (a_rel < 20'(NN));
  assign hit_b    = (b_rel < 20'(NN));
  assign hit_c    = (c_rel < 20'(NN));
  assign a_ix     = a_rel[IW-1:0];
  assign b_ix     = b_rel[IW-1:0];
  assign c_ix     = c_rel[IW-1:0];
  assign unused_ok = ^addr[1:0];

  logic wr_ctrl, wr_clear, wr_start, do_start;
  logic wr_stat, stat_ok, done_clr, err_clr;
  logic wr_ab, err_set, rd_en;

  assign wr_ctrl  = wen & hit_ctrl;
  // clear beats start when both bits are written together
  assign wr_clear = wr_ctrl & wdata[1];
  assign wr_start = wr_ctrl & wdata[0] & ~wdata[1];
  assign do_start = wr_start & ~busy;
  assign wr_stat  = wen & hit_stat;
  assign stat_ok  = ~|wdata[31:3];
  assign done_clr = wr_stat & stat_ok & wdata[1];
  assign err_clr  = wr_stat & stat_ok & wdata[2];
  assign wr_ab    = wen & (hit_a | hit_b) & ~busy;
  assign err_set  = wen & ((wr_start & busy)
                  | (hit_stat & ~stat_ok)
                  | ((hit_a | hit_b) & busy)
                  | ~(hit_ctrl | hit_stat | hit_a | hit_b));
  assign rd_en    = ren & ~wen;

  // Skewed edge feeds: row i / column j lag by i / j cycles
  logic signed [WIDTH-1:0] feed_a [N];
  logic signed [WIDTH-1:0] feed_b [N];

  always_comb begin
    for (int i = 0; i < N; i++) begin
      feed_a[i] = '0;
      feed_b[i] = '0;
      if (busy && int'(cnt_q) >= i && int'(cnt_q) - i < N) begin
        feed_a[i] = a_q[i * N + int'(cnt_q) - i];
        feed_b[i] = b_q[(int'(cnt_q) - i) * N + i];
      end
    end
  end

  logic signed [WIDTH-1:0] a_in [NN];
  logic signed [WIDTH-1:0] b_in [NN];
  logic [PW-1:0]           prod [NN];

  for (genvar gi = 0; gi < N; gi++) begin : g_row
    for (genvar gj = 0; gj < N; gj++) begin : g_col
      localparam int P = gi * N + gj;
      logic signed [PW-1:0] ax, bx;
      if (gj == 0) begin : g_al
        assign a_in[P] = feed_a[gi];
      end else begin : g_ai
        assign a_in[P] = ah_q[P-1];
      end
      if (gi == 0) begin : g_bt
        assign b_in[P] = feed_b[gj];
      end else begin : g_bi
        assign b_in[P] = bv_q[P-N];
      end
      assign ax      = a_in[P];
      assign bx      = b_in[P];
      assign prod[P] = ax * bx;
    end
  end

  // Datapath, register file and read port
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    ah_d     = ah_q;
    bv_d     = bv_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    irq_en_d = irq_en_q;
    err_d    = err_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    if (busy) begin
      cnt_d = cnt_q + 1'b1;
      for (int p = 0; p < NN; p++) begin
        ah_d[p]  = a_in[p];
        bv_d[p]  = b_in[p];
        acc_d[p] = acc_q[p] + prod[p];
      end
    end
    if (wr_ctrl) irq_en_d = wdata[2];
    if (wr_clear) begin
      a_d   = '{default: '0};
      b_d   = '{default: '0};
      ah_d  = '{default: '0};
      bv_d  = '{default: '0};
      acc_d = '{default: '0};
      err_d = 1'b0;
    end else if (do_start) begin
      ah_d  = '{default: '0};
      bv_d  = '{default: '0};
      acc_d = '{default: '0};
      cnt_d = '0;
    end
    if (wr_ab && hit_a) a_d[a_ix] = wdata[WIDTH-1:0];
    if (wr_ab && hit_b) b_d[b_ix] = wdata[WIDTH-1:0];
    if (err_clr) err_d = 1'b0;
    if (err_set) err_d = 1'b1;
    if (rd_en) begin
      rvalid_d = 1'b1;
      rdata_d  = '0;
      if (hit_ctrl)
        rdata_d = PW'({irq_en_q, 2'b00});
      else if (hit_stat)
        rdata_d = PW'({err_q, done, busy});
      else if (hit_a)
        rdata_d = {{WIDTH{a_q[a_ix][WIDTH-1]}}, a_q[a_ix]};
      else if (hit_b)
        rdata_d = {{WIDTH{b_q[b_ix][WIDTH-1]}}, b_q[b_ix]};
      else if (hit_c && !busy)
        rdata_d = acc_q[c_ix];
    end
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (do_start) state_d = S_RUN;
      S_RUN:  if (cnt_q == LAST) state_d = S_DONE;
      S_DONE: begin
        if (do_start)      state_d = S_RUN;
        else if (done_clr) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (wr_clear) state_d = S_IDLE;
  end

  // FSM: outputs
  always_comb begin
    busy   = (state_q == S_RUN);
    done   = (state_q == S_DONE);
    irq    = done & irq_en_q;
    rdata  = rdata_q;
    rvalid = rvalid_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q      <= '{default: '0};
      b_q      <= '{default: '0};
      ah_q     <= '{default: '0};
      bv_q     <= '{default: '0};
      acc_q    <= '{default: '0};
      cnt_q    <= '0;
      irq_en_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      ah_q     <= ah_d;
      bv_q     <= bv_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      irq_en_q <= irq_en_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

endmodule

// File: tb/tb_matmul_accel_nxn.sv
// Bench for matmul_accel_nxn: directed bus traffic, read results
// checked by a queue-based scoreboard against hand-derived values.
module tb_matmul_accel_nxn;
  localparam int W = 16;
  localparam int N = 4;
  localparam logic [21:0] BASE = 22'h000040;

  logic        clk = 1'b0;
  logic        rst, wen, ren;
  logic [21:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        rvalid, irq;

  always #5 clk = ~clk;

  matmul_accel_nxn #(
    .WIDTH(W),
    .N(N),
    .BASE_ADDRESS(32'h1000_0040)
  ) dut (
    .clk(clk),
    .rst(rst),
    .wen(wen),
    .ren(ren),
    .addr(addr),
    .wdata(wdata),
    .rdata(rdata),
    .rvalid(rvalid),
    .irq(irq)
  );

  int nvec = 0;
  int nerr = 0;
  logic [31:0] exp_q [$];
  string       name_q [$];

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", nm, got, exp);
    end
  endtask

  // Monitor: every rvalid pops one expected read
  initial begin
    forever begin
      @(negedge clk);
      if (rvalid === 1'b1) begin
        if (exp_q.size() == 0) begin
          nvec++;
          nerr++;
          $display("FAIL unexpected_rvalid: got rdata %h want no rvalid", rdata);
        end else begin
          string nm;
          logic [31:0] e;
          nm = name_q.pop_front();
          e  = exp_q.pop_front();
          chk(nm, rdata, e);
        end
      end
    end
  end

  function automatic logic [21:0] off_a(int i, int k);
    return 22'(32'h100 + 4 * (i * N + k));
  endfunction
  function automatic logic [21:0] off_b(int k, int j);
    return 22'(32'h200 + 4 * (k * N + j));
  endfunction
  function automatic logic [21:0] off_c(int i, int j);
    return 22'(32'h400 + 4 * (i * N + j));
  endfunction

  task automatic idle(int n);
    repeat (n) begin
      @(negedge clk);
      wen = 1'b0;
      ren = 1'b0;
    end
  endtask

  task automatic wr(logic [21:0] off, logic [31:0] d);
    @(negedge clk);
    wen   = 1'b1;
    ren   = 1'b0;
    addr  = BASE + off;
    wdata = d;
  endtask

  task automatic rd(logic [21:0] off, logic [31:0] e, string nm);
    @(negedge clk);
    wen  = 1'b0;
    ren  = 1'b1;
    addr = BASE + off;
    #1;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  initial begin
    rst = 1'b1; wen = 1'b0; ren = 1'b0;
    addr = '0; wdata = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state
    chk("rst_rvalid", {31'd0, rvalid}, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    rd(22'h004, 32'd0, "rst_status");
    rd(22'h000, 32'd0, "rst_ctrl");
    rd(off_a(0, 0), 32'd0, "rst_a00");
    rd(off_c(0, 0), 32'd0, "rst_c00");

    // Identity x ramp, busy exactly 11 cycles
    for (int i = 0; i < N; i++)
      for (int k = 0; k < N; k++) begin
        wr(off_a(i, k), (i == k) ? 32'd1 : 32'd0);
        wr(off_b(i, k), 32'(i * 4 + k));
      end
    rd(off_a(1, 1), 32'd1, "rb_a11");
    rd(off_b(2, 3), 32'd11, "rb_b23");
    wr(22'h000, 32'd1);
    for (int c = 0; c < 11; c++) rd(22'h004, 32'd1, "busy_cyc");
    rd(22'h004, 32'd2, "done_after_11");
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        rd(off_c(i, j), 32'(i * 4 + j), $sformatf("ident_c%0d%0d", i, j));
    idle(1);
    chk("ident_irq_off", {31'd0, irq}, 32'd0);

    // All -3 times all 7
    for (int p = 0; p < N * N; p++) begin
      wr(22'(32'h100 + 4 * p), 32'h0000_FFFD);
      wr(22'(32'h200 + 4 * p), 32'd7);
    end
    rd(off_a(0, 0), 32'hFFFF_FFFD, "sext_a00");
    wr(22'h000, 32'd1);
    idle(12);
    chk("neg_irq_masked", {31'd0, irq}, 32'd0);
    rd(22'h004, 32'd2, "neg_status");
    rd(off_c(0, 0), 32'hFFFF_FFAC, "neg_c00");
    rd(off_c(3, 3), 32'hFFFF_FFAC, "neg_c33");
    rd(off_c(1, 2), 32'hFFFF_FFAC, "neg_c12");
    wr(22'h000, 32'd4);
    idle(1);
    chk("neg_irq_en", {31'd0, irq}, 32'd1);
    rd(22'h000, 32'd4, "ctrl_rd");
    wr(22'h004, 32'd2);
    idle(1);
    chk("w1c_irq_drop", {31'd0, irq}, 32'd0);
    rd(22'h004, 32'd0, "w1c_status");

    // Max positive operands, wrapping accumulation
    for (int p = 0; p < N * N; p++) begin
      wr(22'(32'h100 + 4 * p), 32'h0000_7FFF);
      wr(22'(32'h200 + 4 * p), 32'h0000_7FFF);
    end
    wr(22'h000, 32'd5);
    idle(12);
    chk("max_irq", {31'd0, irq}, 32'd1);
    rd(off_c(2, 1), 32'hFFFC_0004, "max_c21");
    rd(22'h000, 32'd4, "ctrl_start_rd0");
    wr(22'h004, 32'd2);
    idle(1);
    chk("max_irq_drop", {31'd0, irq}, 32'd0);

    // Accesses while busy
    wr(22'h000, 32'd1);
    idle(2);
    wr(22'h000, 32'd1);
    wr(off_a(0, 0), 32'd0);
    rd(off_c(0, 0), 32'd0, "busy_c_read");
    idle(8);
    rd(22'h004, 32'd6, "busy_err");
    rd(off_c(0, 0), 32'hFFFC_0004, "busy_run_ok");
    rd(off_a(0, 0), 32'h0000_7FFF, "busy_a_kept");
    wr(22'h004, 32'd4);
    rd(22'h004, 32'd2, "err_w1c");
    wr(22'h004, 32'd2);

    // Reset mid-run, then a fresh run
    wr(22'h000, 32'd1);
    idle(4);
    @(negedge clk);
    rst = 1'b1; wen = 1'b0; ren = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    rd(22'h004, 32'd0, "mid_rst_status");
    rd(off_c(0, 0), 32'd0, "mid_rst_c00");
    rd(off_c(3, 3), 32'd0, "mid_rst_c33");
    for (int i = 0; i < N; i++) begin
      wr(off_a(i, i), 32'd2);
      for (int j = 0; j < N; j++) wr(off_b(i, j), 32'(i - j));
    end
    wr(22'h000, 32'd1);
    idle(12);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        rd(off_c(i, j), 32'(2 * (i - j)), $sformatf("fresh_c%0d%0d", i, j));

    // Same-cycle write and read
    @(negedge clk);
    wen = 1'b1; ren = 1'b1;
    addr = BASE + off_a(0, 1); wdata = 32'h0000_1234;
    idle(1);
    chk("wr_rd_rvalid", {31'd0, rvalid}, 32'd0);
    rd(off_a(0, 1), 32'h0000_1234, "wr_rd_write");

    // Error on C write, then clear+start
    wr(off_c(0, 0), 32'd5);
    rd(22'h004, 32'd6, "c_write_err");
    wr(22'h000, 32'd3);
    rd(22'h004, 32'd0, "clear_status");
    rd(off_a(0, 1), 32'd0, "clear_a01");
    rd(off_c(3, 0), 32'd0, "clear_c30");
    rd(22'h300, 32'd0, "unmapped_rd");
    rd(22'h004, 32'd0, "unmapped_no_err");

    // Clear aborts a run
    wr(22'h000, 32'd1);
    idle(2);
    wr(22'h000, 32'd2);
    rd(22'h004, 32'd0, "clear_abort");

    idle(3);
    if (exp_q.size() != 0) begin
      nvec++;
      nerr++;
      $display("FAIL missing_rvalid: got %0d pending want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
